// File: rtl/add_round_key_seq_if.sv
// Handshake bundle for the AddRoundKey stage.
//   in_valid / in_ready / in_data     : state words arriving from MixColumns
//   out_valid / out_ready / out_data  : state XOR round key
//   out_round                         : index (0..10) of the round key applied
// The slave modport is the stage itself; master is the upstream/downstream side.
interface add_round_key_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_round
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_round
    );
endinterface

// File: rtl/add_round_key_seq.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// Each accepted 128-bit state is XORed with the current round key and issued on
// a registered valid/ready output. After every accept the next round key is
// derived over two cycles (EXP1: SubWord/RotWord/Rcon, EXP2: word chaining).
// One key serves rounds 0..10; afterwards the block waits for a new key_load.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_load     : one-cycle pulse, loads key_in as round key 0 (highest priority)
//   key_in       : cipher key, w0 = [127:96]
//   bus          : handshake bundle (slave side)
//   busy         : key loaded and rounds remaining

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. The inverse is x^254, built from the squares x^2..x^128.
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq [1:7];
    logic [7:0] inv;

    always_comb begin
        sq[1] = gf_mul(in_byte, in_byte);
        for (int i = 2; i <= 7; i++) begin
            sq[i] = gf_mul(sq[i-1], sq[i-1]);
        end
        // 2+4+8+16+32+64+128 = 254; zero maps to zero as required
        inv = sq[1];
        for (int i = 2; i <= 7; i++) begin
            inv = gf_mul(inv, sq[i]);
        end
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module add_round_key_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [127:0]         key_in,
    add_round_key_seq_if.slave   bus,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, READY, EXP1, EXP2, DONE} state_t;

    state_t       state_reg;
    logic [127:0] rk_reg;
    logic [3:0]   round_reg;
    logic [7:0]   rcon_reg;
    logic [31:0]  t_reg;
    logic         out_valid_reg;
    logic [127:0] out_data_reg;
    logic [3:0]   out_round_reg;

    logic         in_ready;
    logic         accept;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [127:0] rk_next;

    // No path from in_valid: only state, the output register, out_ready, key_load.
    assign in_ready = (state_reg == READY) && !key_load
                    && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_round = out_round_reg;
    assign busy = (state_reg == READY) || (state_reg == EXP1) || (state_reg == EXP2);

    // RotWord of the last key word, then SubWord through four S-boxes
    assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            sbox u_sbox (
                .in_byte  (rot_word[8*gi +: 8]),
                .out_byte (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    // Word chaining of the key schedule: each new word folds in the previous one
    always_comb begin
        rk_next[127:96] = rk_reg[127:96] ^ t_reg;
        rk_next[95:64]  = rk_reg[95:64]  ^ rk_next[127:96];
        rk_next[63:32]  = rk_reg[63:32]  ^ rk_next[95:64];
        rk_next[31:0]   = rk_reg[31:0]   ^ rk_next[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rk_reg        <= '0;
            round_reg     <= '0;
            rcon_reg      <= 8'h01;
            t_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_round_reg <= '0;
        end else if (key_load) begin
            // Restart with the new key; any pending output is discarded
            state_reg     <= READY;
            rk_reg        <= key_in;
            round_reg     <= '0;
            rcon_reg      <= 8'h01;
            out_valid_reg <= 1'b0;
        end else begin
            // Output register: refill wins over drain in the same cycle
            if (accept) begin
                out_data_reg  <= bus.in_data ^ rk_reg;
                out_round_reg <= round_reg;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end

            unique case (state_reg)
                READY: begin
                    if (accept) begin
                        state_reg <= (round_reg == 4'd10) ? DONE : EXP1;
                    end
                end
                EXP1: begin
                    t_reg     <= sub_word ^ {rcon_reg, 24'h0};
                    state_reg <= EXP2;
                end
                EXP2: begin
                    rk_reg    <= rk_next;
                    round_reg <= round_reg + 4'd1;
                    rcon_reg  <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
                    state_reg <= READY;
                end
                default: begin
                    // IDLE and DONE hold until key_load
                    state_reg <= state_reg;
                end
            endcase
        end
    end
endmodule

// File: doc/add_round_key_seq.md
# add_round_key_seq

Sequential AddRoundKey stage with on-the-fly AES-128 key expansion. It sits directly downstream of the MixColumns stage. Each 128-bit state word it accepts is XORed with the current round key, and the result is issued on a registered valid/ready output. After each accepted state it derives the next round key over two cycles. One instance serves one encryption: round keys 0 through 10, then it waits for a new key.

## Interface
Parameters: none (AES-128 only).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_load  in  1  one-cycle pulse; loads key_in as round key 0
- key_in  in  128  cipher key; word w0 = [127:96], byte 0 = [127:120]
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- in_data  in  128  state, column-major; column 0 = [127:96], same packing as MixColumns output
- out_valid  out  1  out_data/out_round valid
- out_ready  in  1  consumer accepts output
- out_data  out  128  in_data XOR round key
- out_round  out  4  round index (0..10) of the key that was applied
- busy  out  1  key loaded and rounds remaining (state != IDLE, != DONE)

## Operation
- State machine: IDLE, READY, EXP1, EXP2, DONE.
- IDLE: no key. in_ready = 0. key_load -> READY, rk <= key_in, round <= 0, rcon <= 8'h01.
- READY: in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready: out_data <= in_data ^ rk, out_round <= round, out_valid <= 1.
  - Then: if round == 10 -> DONE; else -> EXP1.
- EXP1: t <= SubWord(RotWord(rk[31:0])) ^ {rcon, 24'h0}, registered. Four instances of the codebase sbox module (8-bit combinational). -> EXP2.
- EXP2: new w0 = rk[127:96]^t, w1 = rk[95:64]^w0, w2 = rk[63:32]^w1, w3 = rk[31:0]^w2.
  - rk <= {w0,w1,w2,w3}; round <= round+1.
  - rcon <= xtime(rcon): shift left 1, XOR 8'h1b if bit7 was set; 0x80 -> 0x1b.
  - -> READY.
- DONE: in_ready = 0. Waits for key_load.
- key_load in any state:
  - Highest priority. Restarts at round 0 (-> READY with the new key) and drops out_valid to 0.
  - A pending output is flushed.
  - in_ready is forced 0 in the key_load cycle.
- Output register: out_valid clears on out_valid && out_ready unless a new accept happens in the same cycle (simultaneous drain and refill allowed in READY).
- out_data/out_round hold stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_round 0, busy 0, state IDLE, rk 0, round 0, rcon 8'h01.
- Latency: accept at edge N -> out_valid at edge N (registered, visible in cycle N+1).
- Key schedule: accept at N, EXP1 at N+1, EXP2 at N+2, READY (in_ready can assert) in cycle N+3. Peak throughput is one state per 3 cycles.
- key_load -> in_ready can assert the next cycle.
- in_ready depends combinationally on out_ready and key_load only; no path from in_valid.
- Backpressure: if out_valid && !out_ready in READY, in_ready = 0. Key expansion proceeds regardless of output stall.
- Reset asserted mid-expansion: everything returns to reset values immediately; no output emitted.

## Test plan
- Reset / idle:
  - Stimulus: reset, then in_valid=1 with no key.
  - Required: in_ready stays 0; all outputs 0; busy 0.
- Round 0:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734.
  - Required: out_data 193de3bea0f4e22b9ac68d2ae9f84808, out_round 0.
- Full schedule:
  - Stimulus: same key, 11 states of all-zero, out_ready=1.
  - Required:
    - round 1 out_data a0fafe1788542cb123a339392a6c7605;
    - round 10 out_data d014f9a8c9ee2589e13f0cc8b6630ca6;
    - then state DONE, busy 0, in_ready 0.
  - Check: accept spacing is exactly 3 cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 after round 2 output.
  - Required: out_data/out_round stable; in_ready 0 after expansion; on release the next round (3) is accepted in the same cycle the drain occurs.
- Mid-run reload:
  - Stimulus: key_load with a new key during EXP1 of round 4, with out_valid pending.
  - Required: out_valid drops; the next accepted state gets out_round 0 and is XORed with the new key.
- Async reset:
  - Stimulus: rst_n low during EXP2.
  - Required: outputs zero without waiting for a clock edge; restart from IDLE.
